mmi_arbiter: RTL and testbench
==============================

MMI_ARBITER -- requirements
Module: mmi_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have ports a_valid (in, 1), a_addr (in, 3), a_wstrb (in, 4), a_wdata (in, 32), a_rdata (out, 32) and a_ready (out, 1): requester A (CPU bus interface) register port.
REQ-004 The block SHALL have ports b_valid, b_addr, b_wstrb, b_wdata, b_rdata and b_ready, with widths and directions identical to port A: requester B (coprocessor control) register port.
REQ-005 The block SHALL have ports m_valid (out, 1), m_addr (out, 3), m_wstrb (out, 4), m_wdata (out, 32), m_rdata (in, 32) and m_ready (in, 1): shared downstream port to mmi_top.
REQ-006 The block SHALL have port err (out, 1): sticky timeout flag.

Function
REQ-007 Requester protocol SHALL be: valid and payload held stable until a one-cycle ready pulse; wstrb=0 is a read and wstrb!=0 is a write.
REQ-008 The FSM SHALL have three states: IDLE, BUSY_A and BUSY_B.
REQ-009 In IDLE with exactly one valid asserted, the FSM SHALL enter BUSY_x on the next edge.
REQ-010 On entry to BUSY_x, m_valid SHALL assert with m_addr, m_wstrb and m_wdata registered from requester x.
REQ-011 Request-to-m_valid latency SHALL be 1 cycle.
REQ-012 In IDLE with a_valid and b_valid both asserted, the FSM SHALL grant the requester not granted last (round-robin).
REQ-013 The last-grant register SHALL reset to B, so A wins the first simultaneous contest.
REQ-014 In BUSY_x with m_ready=1, x_ready SHALL pulse combinationally for that cycle with x_rdata=m_rdata.
REQ-015 In the cycle m_ready=1, m_valid SHALL deassert at the next edge and the FSM SHALL return to IDLE.
REQ-016 There SHALL be a minimum of 1 IDLE cycle between transactions; back-to-back requests from both sides SHALL alternate A,B,A,B.
REQ-017 x_ready SHALL be 0 in every state other than BUSY_x.
REQ-018 x_rdata SHALL be 0 whenever x_ready=0.
REQ-019 A request arriving during BUSY SHALL wait; it SHALL NOT be dropped or reordered.
REQ-020 If the granted requester drops valid mid-transaction (a protocol violation), the downstream transaction SHALL still complete and its ready pulse SHALL be discarded.
REQ-021 m_ready asserted while in IDLE SHALL be ignored.

Reset
REQ-022 On resetn=0, asynchronously: state=IDLE, m_valid=0, m_addr=0, m_wstrb=0, m_wdata=0, a_ready=0, b_ready=0, err=0, last-grant=B, timeout counter=0.
REQ-023 Reset asserted mid-transaction SHALL abort without any ready pulse; the requester SHALL re-issue.

Configuration
REQ-024 With macro MMI_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle with m_ready=0.
REQ-025 With MMI_ARB_TIMEOUT_EN defined, when the counter reaches 255 the block SHALL pulse x_ready with x_rdata=32'hDEADBEEF, drop m_valid, return to IDLE and set err, which is cleared only by reset.
REQ-026 Without MMI_ARB_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied 0 and BUSY SHALL wait indefinitely for m_ready.

Verification
REQ-027 A reads addr 3, m_ready after 2 cycles with m_rdata=32'h0000_00A5 -> m_valid 1 cycle after a_valid; a_ready 1 cycle with a_rdata=32'hA5; b_ready stays 0.
REQ-028 A and B valid in the same cycle out of reset -> A granted first, B granted after 1 IDLE cycle; m_addr tracks each requester.
REQ-029 Both requesters held valid for 4 transactions, m_ready=1 immediately -> grant order A,B,A,B; m_valid pattern 1,0 repeating.
REQ-030 B writes wdata=32'h1234_5678, wstrb=4'hF, addr 5 -> m_wdata, m_wstrb and m_addr match exactly while m_valid=1; b_ready pulses once.
REQ-031 resetn pulsed low while in BUSY_A -> all outputs 0 immediately, no a_ready; A re-issues and completes normally.
REQ-032 With MMI_ARB_TIMEOUT_EN, m_ready held 0 -> a_ready at BUSY cycle 256 with a_rdata=32'hDEADBEEF and err=1 held until reset; without the macro, no a_ready after 1000 cycles and err=0.

Source files
------------

// File: rtl/mmi_arbiter.sv
// ============================================================================
//  Module   : mmi_arbiter
//  Purpose  : Two-requester round-robin arbiter (A = CPU, B = coprocessor)
//             onto a single downstream register port; optional bus timeout
//             enabled by defining MMI_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmi_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_valid,
    input  logic [2:0]  a_addr,
    input  logic [3:0]  a_wstrb,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [2:0]  b_addr,
    input  logic [3:0]  b_wstrb,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_ready,
    output logic        m_valid,
    output logic [2:0]  m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        err
);

    localparam logic [31:0] c_TMO_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_A = 2'd1,
        ST_BUSY_B = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_b;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_done;
    logic        w_busy;
    logic        w_timeout;
    logic [31:0] w_resp_data;

    assign w_busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie, A wins only if B held the last grant
                if (a_valid && (!b_valid || r_last_b)) begin
                    w_grant_a   = 1'b1;
                    w_state_nxt = ST_BUSY_A;
                end else if (b_valid) begin
                    w_grant_b   = 1'b1;
                    w_state_nxt = ST_BUSY_B;
                end
            end
            ST_BUSY_A, ST_BUSY_B: begin
                if (m_ready || w_timeout) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Completion is only reported to a requester still holding valid
    assign w_resp_data = w_timeout ? c_TMO_RDATA : m_rdata;
    assign a_ready     = (r_state == ST_BUSY_A) && w_done && a_valid;
    assign b_ready     = (r_state == ST_BUSY_B) && w_done && b_valid;
    assign a_rdata     = a_ready ? w_resp_data : 32'd0;
    assign b_rdata     = b_ready ? w_resp_data : 32'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_last_b <= 1'b1;
            m_valid  <= 1'b0;
            m_addr   <= 3'd0;
            m_wstrb  <= 4'd0;
            m_wdata  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_a) begin
                r_last_b <= 1'b0;
                m_valid  <= 1'b1;
                m_addr   <= a_addr;
                m_wstrb  <= a_wstrb;
                m_wdata  <= a_wdata;
            end else if (w_grant_b) begin
                r_last_b <= 1'b1;
                m_valid  <= 1'b1;
                m_addr   <= b_addr;
                m_wstrb  <= b_wstrb;
                m_wdata  <= b_wdata;
            end else if (w_done) begin
                m_valid  <= 1'b0;
            end
        end
    end

`ifdef MMI_ARB_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_err;

    // Fires on the 256th consecutive stalled BUSY cycle
    assign w_timeout = w_busy && !m_ready && (r_tmo_cnt == 8'hFF);
    assign err       = r_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant_a || w_grant_b) begin
                r_tmo_cnt <= 8'd0;
            end else if (w_busy && !m_ready) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmi_arbiter.sv
// ============================================================================
//  Module   : tb_mmi_arbiter
//  Purpose  : Self-checking bench for mmi_arbiter (vector table, directed
//             corner sequences, randomized traffic against a reference model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmi_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_valid, b_valid, m_valid, m_ready;
    logic [2:0]  a_addr, b_addr, m_addr;
    logic [3:0]  a_wstrb, b_wstrb, m_wstrb;
    logic [31:0] a_wdata, b_wdata, m_wdata, a_rdata, b_rdata, m_rdata;
    logic        a_ready, b_ready, err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmi_arbiter dut (
        .clk     (clk),
        .resetn  (resetn),
        .a_valid (a_valid),
        .a_addr  (a_addr),
        .a_wstrb (a_wstrb),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_addr  (b_addr),
        .b_wstrb (b_wstrb),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata),
        .b_ready (b_ready),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wstrb (m_wstrb),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .err     (err)
    );

    typedef struct {
        logic        av;
        logic [2:0]  aad;
        logic [3:0]  aws;
        logic [31:0] awd;
        logic        bv;
        logic [2:0]  bad;
        logic [3:0]  bws;
        logic [31:0] bwd;
        logic        mr;
        logic [31:0] mrd;
        logic        emv;
        logic [2:0]  ead;
        logic [3:0]  ews;
        logic [31:0] ewd;
        logic        ear;
        logic [31:0] eard;
        logic        ebr;
        logic [31:0] ebrd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        a_valid = 0; a_addr = 0; a_wstrb = 0; a_wdata = 0;
        b_valid = 0; b_addr = 0; b_wstrb = 0; b_wdata = 0;
        m_ready = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mvalid"}, m_valid, 0);
        chk({nm, "_maddr"},  m_addr, 0);
        chk({nm, "_mwstrb"}, m_wstrb, 0);
        chk({nm, "_mwdata"}, m_wdata, 0);
        chk({nm, "_aready"}, a_ready, 0);
        chk({nm, "_ardata"}, a_rdata, 0);
        chk({nm, "_bready"}, b_ready, 0);
        chk({nm, "_brdata"}, b_rdata, 0);
        chk({nm, "_err"},    err, 0);
    endtask

    vec_t vt[16];

    // Reference model state (transaction level: who owns the bus, who won last)
    int          owner;      // 0 none, 1 A, 2 B
    int          last;       // 1 A, 2 B
    logic        a_pend, b_pend;
    logic [2:0]  cap_addr;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;

    initial begin
        resetn = 1'b0;
        clear_inputs();
        m_ready = 1'b1;
        m_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        m_ready = 1'b0;
        m_rdata = 0;
        resetn = 1'b1;

        //        av aad  aws awd           bv bad  bws  bwd            mr mrd            emv ead  ews  ewd           ear eard          ebr ebrd
        vt[0]  = '{1, 3'd1, 0, 0,           1, 3'd6, 0,   0,            0, 0,             0, 0,    0,   0,            0, 0,            0, 0};
        vt[1]  = '{1, 3'd1, 0, 0,           1, 3'd6, 0,   0,            1, 32'h11,        1, 3'd1, 0,   0,            1, 32'h11,       0, 0};
        vt[2]  = '{0, 0,    0, 0,           1, 3'd6, 0,   0,            0, 0,             0, 0,    0,   0,            0, 0,            0, 0};
        vt[3]  = '{0, 0,    0, 0,           1, 3'd6, 0,   0,            1, 32'h22,        1, 3'd6, 0,   0,            0, 0,            1, 32'h22};
        vt[4]  = '{0, 0,    0, 0,           0, 0,    0,   0,            0, 0,             0, 0,    0,   0,            0, 0,            0, 0};
        vt[5]  = '{1, 3'd3, 0, 0,           0, 0,    0,   0,            0, 0,             0, 0,    0,   0,            0, 0,            0, 0};
        vt[6]  = '{1, 3'd3, 0, 0,           0, 0,    0,   0,            0, 0,             1, 3'd3, 0,   0,            0, 0,            0, 0};
        vt[7]  = '{1, 3'd3, 0, 0,           1, 3'd2, 0,   0,            0, 0,             1, 3'd3, 0,   0,            0, 0,            0, 0};
        vt[8]  = '{1, 3'd3, 0, 0,           1, 3'd2, 0,   0,            1, 32'hA5,        1, 3'd3, 0,   0,            1, 32'hA5,       0, 0};
        vt[9]  = '{0, 0,    0, 0,           1, 3'd2, 0,   0,            0, 0,             0, 0,    0,   0,            0, 0,            0, 0};
        vt[10] = '{0, 0,    0, 0,           1, 3'd2, 0,   0,            1, 32'hFF,        1, 3'd2, 0,   0,            0, 0,            1, 32'hFF};
        vt[11] = '{0, 0,    0, 0,           0, 0,    0,   0,            1, 32'h77,        0, 0,    0,   0,            0, 0,            0, 0};
        vt[12] = '{0, 0,    0, 0,           1, 3'd5, 4'hF, 32'h12345678, 0, 0,            0, 0,    0,   0,            0, 0,            0, 0};
        vt[13] = '{0, 0,    0, 0,           1, 3'd5, 4'hF, 32'h12345678, 0, 0,            1, 3'd5, 4'hF, 32'h12345678, 0, 0,           0, 0};
        vt[14] = '{0, 0,    0, 0,           1, 3'd5, 4'hF, 32'h12345678, 1, 0,            1, 3'd5, 4'hF, 32'h12345678, 0, 0,           1, 0};
        vt[15] = '{0, 0,    0, 0,           0, 0,    0,   0,            0, 0,             0, 0,    0,   0,            0, 0,            0, 0};

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            a_valid = vt[i].av; a_addr = vt[i].aad; a_wstrb = vt[i].aws; a_wdata = vt[i].awd;
            b_valid = vt[i].bv; b_addr = vt[i].bad; b_wstrb = vt[i].bws; b_wdata = vt[i].bwd;
            m_ready = vt[i].mr; m_rdata = vt[i].mrd;
            @(negedge clk);
            chk($sformatf("v%0d_mvalid", i), m_valid, vt[i].emv);
            chk($sformatf("v%0d_aready", i), a_ready, vt[i].ear);
            chk($sformatf("v%0d_ardata", i), a_rdata, vt[i].eard);
            chk($sformatf("v%0d_bready", i), b_ready, vt[i].ebr);
            chk($sformatf("v%0d_brdata", i), b_rdata, vt[i].ebrd);
            if (vt[i].emv) begin
                chk($sformatf("v%0d_maddr", i),  m_addr,  vt[i].ead);
                chk($sformatf("v%0d_mwstrb", i), m_wstrb, vt[i].ews);
                chk($sformatf("v%0d_mwdata", i), m_wdata, vt[i].ewd);
            end
        end

        // Both sides continuously requesting, downstream always ready
        @(posedge clk);
        #1;
        a_valid = 1; a_addr = 3'd2; b_valid = 1; b_addr = 3'd4;
        m_ready = 1; m_rdata = 32'h5A5A_0000;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_mvalid", c), m_valid, (c % 2) == 1);
            chk($sformatf("rr%0d_aready", c), a_ready, (c % 4) == 1);
            chk($sformatf("rr%0d_bready", c), b_ready, (c % 4) == 3);
            if (c % 2 == 1)
                chk($sformatf("rr%0d_maddr", c), m_addr, ((c % 4) == 1) ? 3'd2 : 3'd4);
        end

        // Reset in the middle of a BUSY_A transaction
        do_reset();
        @(posedge clk);
        #1;
        a_valid = 1; a_addr = 3'd7;
        @(posedge clk);
        #1;
        chk("rst_mid_busy_mvalid", m_valid, 1);
        #1;
        resetn = 0;
        m_ready = 1; m_rdata = 32'hCAFE_0001;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        resetn = 1; m_ready = 0;
        @(negedge clk);
        chk("reissue_mvalid", m_valid, 1);
        chk("reissue_maddr", m_addr, 3'd7);
        @(posedge clk);
        #1;
        m_ready = 1; m_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("reissue_aready", a_ready, 1);
        chk("reissue_ardata", a_rdata, 32'h0BAD_F00D);

        // Stalled downstream
        do_reset();
        begin
            int busy_cycles;
            int ready_seen;
            busy_cycles = 0;
            ready_seen  = 0;
            @(posedge clk);
            #1;
            a_valid = 1; a_addr = 3'd1;
`ifdef MMI_ARB_TIMEOUT_EN
            for (int c = 0; c < 1100 && ready_seen == 0; c++) begin
                @(negedge clk);
                if (m_valid) busy_cycles++;
                if (a_ready) begin
                    ready_seen = 1;
                    chk("tmo_cycle", busy_cycles, 256);
                    chk("tmo_rdata", a_rdata, 32'hDEAD_BEEF);
                end
            end
            chk("tmo_seen", ready_seen, 1);
            @(posedge clk);
            #1;
            a_valid = 0;
            repeat (3) @(negedge clk);
            chk("tmo_err_sticky", err, 1);
            chk("tmo_mvalid_low", m_valid, 0);
            do_reset();
            @(negedge clk);
            chk("tmo_err_cleared", err, 0);
`else
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                if (a_ready) ready_seen++;
            end
            chk("notmo_no_ready", ready_seen, 0);
            chk("notmo_err", err, 0);
            chk("notmo_still_busy", m_valid, 1);
            do_reset();
`endif
        end

        // Randomized traffic against the transaction-level model
        do_reset();
        owner = 0; last = 2; a_pend = 0; b_pend = 0;
        cap_addr = 0; cap_wstrb = 0; cap_wdata = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            if (owner != 0 && m_ready) begin
                if (owner == 1) a_pend = 0; else b_pend = 0;
                owner = 0;
            end else if (owner == 0 && (a_valid || b_valid)) begin
                if (a_valid && b_valid) owner = (last == 2) ? 1 : 2;
                else owner = a_valid ? 1 : 2;
                last = owner;
                cap_addr  = (owner == 1) ? a_addr  : b_addr;
                cap_wstrb = (owner == 1) ? a_wstrb : b_wstrb;
                cap_wdata = (owner == 1) ? a_wdata : b_wdata;
            end
            #1;
            if (!a_pend && $urandom_range(1, 0) == 1) begin
                a_pend = 1; a_addr = 3'($urandom);
                a_wstrb = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'd0;
                a_wdata = $urandom;
            end
            if (!b_pend && $urandom_range(1, 0) == 1) begin
                b_pend = 1; b_addr = 3'($urandom);
                b_wstrb = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'd0;
                b_wdata = $urandom;
            end
            a_valid = a_pend;
            b_valid = b_pend;
            m_ready = 1'($urandom_range(1, 0));
            m_rdata = $urandom;
            @(negedge clk);
            chk($sformatf("rnd%0d_mvalid", c), m_valid, owner != 0);
            chk($sformatf("rnd%0d_aready", c), a_ready, owner == 1 && m_ready);
            chk($sformatf("rnd%0d_ardata", c), a_rdata, (owner == 1 && m_ready) ? m_rdata : 32'd0);
            chk($sformatf("rnd%0d_bready", c), b_ready, owner == 2 && m_ready);
            chk($sformatf("rnd%0d_brdata", c), b_rdata, (owner == 2 && m_ready) ? m_rdata : 32'd0);
            if (owner != 0) begin
                chk($sformatf("rnd%0d_maddr", c),  m_addr,  cap_addr);
                chk($sformatf("rnd%0d_mwstrb", c), m_wstrb, cap_wstrb);
                chk($sformatf("rnd%0d_mwdata", c), m_wdata, cap_wdata);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
